// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory arbiter:
// scanner states and the response-owner tag.
package dm_pkg;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_PEND = 2'd1,
    S_RESP = 2'd2
  } scan_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_SCAN = 2'd2
  } tag_t;

  // Owner of next cycle's read data.
  // Writes never produce a response.
  function automatic tag_t owner_tag(
    input logic cpu_rd,
    input logic scan_rd
  );
    tag_t t;
    t = TAG_NONE;
    if (scan_rd) t = TAG_SCAN;
    else if (cpu_rd) t = TAG_CPU;
    return t;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// CPU MEM-stage access port of the data-memory
// arbiter: request/grant plus read response.
interface dm_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  modport master (
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    input  cpu_gnt,
    input  cpu_rdata,
    input  cpu_rvalid
  );

  modport slave (
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    output cpu_gnt,
    output cpu_rdata,
    output cpu_rvalid
  );

endinterface

// File: rtl/dm_scanner.sv
// Debug display scanner: periodically reads one
// data-memory word and holds the last result.
import dm_pkg::*;

module dm_scanner #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int SCAN_DIV = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_en,
  input  logic              scan_gnt,
  input  logic              rsp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              scan_req,
  output logic [ADDR_W-1:0] scan_ptr,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(SCAN_DIV - 1);

  scan_state_t      state;
  scan_state_t      state_nx;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nx;

  // State and divider registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_WAIT;
      div   <= '0;
    end else begin
      state <= state_nx;
      div   <= div_nx;
    end
  end

  // Next state, divider and read request.
  always_comb begin
    state_nx = state;
    div_nx   = div;
    scan_req = 1'b0;
    unique case (state)
      S_WAIT: begin
        if (!scan_en) begin
          div_nx = '0;
        end else if (div == DIV_LAST) begin
          div_nx   = '0;
          state_nx = S_PEND;
        end else begin
          div_nx = div + 1'b1;
        end
      end
      S_PEND: begin
        scan_req = scan_en;
        if (!scan_en) state_nx = S_WAIT;
        else if (scan_gnt) state_nx = S_RESP;
      end
      S_RESP: state_nx = S_WAIT;
      default: state_nx = S_WAIT;
    endcase
  end

  // Capture the routed response and advance
  // the pointer; it wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_ptr  <= '0;
      scan_addr <= '0;
      scan_data <= '0;
    end else if (rsp) begin
      scan_data <= mem_rdata;
      scan_addr <= scan_ptr;
      scan_ptr  <= scan_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: CPU has priority, the
// scanner gets one forced slot when starved.
import dm_pkg::*;

module dm_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int SCAN_DIV   = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  dm_arbiter_if.slave       cpu,
  input  logic              scan_en,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP =
    SW'(STARVE_MAX);

  logic              scan_req;
  logic              scan_gnt;
  logic              cpu_gnt;
  logic              forced;
  logic [ADDR_W-1:0] scan_ptr;
  logic [SW-1:0]     starve_cnt;
  tag_t              tag;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid;

  dm_scanner #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .scan_en   (scan_en),
    .scan_gnt  (scan_gnt),
    .rsp       (tag == TAG_SCAN),
    .mem_rdata (mem_rdata),
    .scan_req  (scan_req),
    .scan_ptr  (scan_ptr),
    .scan_addr (scan_addr),
    .scan_data (scan_data)
  );

  // Single owner per cycle; starvation flips
  // priority for exactly one cycle.
  always_comb begin
    forced   = scan_req && (starve_cnt == STARVE_TOP);
    cpu_gnt  = cpu.cpu_req && !forced;
    scan_gnt = scan_req && (forced || !cpu.cpu_req);
  end

  // Memory command from the current grant;
  // writes are blocked while in reset.
  always_comb begin
    mem_addr  = cpu.cpu_addr;
    mem_wdata = cpu.cpu_wdata;
    mem_we    = 1'b0;
    unique case (1'b1)
      scan_gnt: mem_addr = scan_ptr;
      cpu_gnt:  mem_we   = cpu.cpu_we && !rst;
      default:  ;
    endcase
  end

  // Count denied pending cycles, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (scan_req && !scan_gnt) begin
      if (starve_cnt != STARVE_TOP)
        starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Tag who owns next cycle's read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag <= TAG_NONE;
    else tag <= owner_tag(cpu_gnt && !cpu.cpu_we,
                          scan_gnt);
  end

  // Hold the last CPU read result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else if (rvalid) rdata_q <= mem_rdata;
  end

  assign rvalid         = (tag == TAG_CPU);
  assign cpu.cpu_gnt    = cpu_gnt;
  assign cpu.cpu_rvalid = rvalid;
  assign cpu.cpu_rdata  = rvalid ? mem_rdata : rdata_q;

endmodule
